// File: rtl/trace_pkg.sv
// Shared types and constants for the cycle-accurate trace recorder.
// State encodings mirror the core, fetcher and LSU state machines.
package trace_pkg;

    localparam int INSTR_BITS = 16;
    localparam int TRACE_CYCLE_BITS = 16;
    localparam int TRACE_PC_BITS = 8;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [2:0] {
        FETCH_IDLE     = 3'b000,
        FETCH_FETCHING = 3'b001,
        FETCH_FETCHED  = 3'b010
    } fetcher_state_e;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_e;

    localparam core_state_e    CORE_RESET  = CORE_IDLE;
    localparam fetcher_state_e FETCH_RESET = FETCH_IDLE;
    localparam lsu_state_e     LSU_RESET   = LSU_IDLE;

    typedef struct packed {
        logic [TRACE_CYCLE_BITS-1:0] cycle;
        logic [2:0]                  core_state;
        logic [2:0]                  fetcher_state;
        logic [1:0]                  lsu_state;
        logic [TRACE_PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0]       instruction;
    } trace_record_t;

endpackage

// File: rtl/core_trace_capture_if.sv
// Record drain channel between the trace unit and its consumer.
// Producer drives valid plus head fields; consumer drives ready.
interface core_trace_capture_if
    import trace_pkg::*;
#(
    parameter int CYCLE_BITS = 16,
    parameter int PC_BITS    = 8
);
    logic                  rec_valid;
    logic                  rec_ready;
    logic [CYCLE_BITS-1:0] rec_cycle;
    logic [2:0]            rec_core_state;
    logic [2:0]            rec_fetcher_state;
    logic [1:0]            rec_lsu_state;
    logic [PC_BITS-1:0]    rec_pc;
    logic [INSTR_BITS-1:0] rec_instruction;

    modport master (
        output rec_valid, rec_cycle, rec_core_state,
        output rec_fetcher_state, rec_lsu_state,
        output rec_pc, rec_instruction,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_cycle, rec_core_state,
        input  rec_fetcher_state, rec_lsu_state,
        input  rec_pc, rec_instruction,
        output rec_ready
    );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; the explicit count is the only full/empty source.
// Head data reads as zero while empty.
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    T            mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/core_trace_capture.sv
// Trace recorder: timestamps a record whenever a selected state field changes
// and queues it for a valid/ready consumer, counting records lost to a full FIFO.
module core_trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CYCLE_BITS = 16,
    parameter int PC_BITS    = 8,
    parameter int DROP_BITS  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2:0]             trigger_mask,
    input  logic [2:0]             core_state,
    input  logic [2:0]             fetcher_state,
    input  logic [1:0]             lsu_state,
    input  logic [PC_BITS-1:0]     current_pc,
    input  logic [INSTR_BITS-1:0]  instruction,
    core_trace_capture_if.master   rec,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_BITS-1:0]   dropped
);
    typedef struct packed {
        logic [CYCLE_BITS-1:0] cycle;
        logic [2:0]            core_state;
        logic [2:0]            fetcher_state;
        logic [1:0]            lsu_state;
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] instruction;
    } rec_t;

    logic [CYCLE_BITS-1:0] cycle_q;
    logic [2:0]            prev_core;
    logic [2:0]            prev_fetch;
    logic [1:0]            prev_lsu;
    logic [2:0]            changed;
    logic                  hit;
    logic                  push;
    logic                  drop;
    logic                  full;
    logic                  empty;
    rec_t                  din;
    rec_t                  head;

    assign changed = {lsu_state != prev_lsu,
                      fetcher_state != prev_fetch,
                      core_state != prev_core};
    assign hit  = enable & |(trigger_mask & changed);
    assign push = hit & ~reset;
    assign drop = push & full & ~rec.rec_ready;

    assign din = '{
        cycle:         cycle_q,
        core_state:    core_state,
        fetcher_state: fetcher_state,
        lsu_state:     lsu_state,
        pc:            current_pc,
        instruction:   instruction
    };

    // Stamp counter and change history run regardless of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q    <= '0;
            prev_core  <= CORE_RESET;
            prev_fetch <= FETCH_RESET;
            prev_lsu   <= LSU_RESET;
            overflow   <= 1'b0;
            dropped    <= '0;
        end else begin
            cycle_q    <= cycle_q + CYCLE_BITS'(1);
            prev_core  <= core_state;
            prev_fetch <= fetcher_state;
            prev_lsu   <= lsu_state;
            if (drop) begin
                overflow <= 1'b1;
                if (dropped != '1) begin
                    dropped <= dropped + DROP_BITS'(1);
                end
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (rec_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (rec.rec_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign rec.rec_valid         = ~empty;
    assign rec.rec_cycle         = head.cycle;
    assign rec.rec_core_state    = head.core_state;
    assign rec.rec_fetcher_state = head.fetcher_state;
    assign rec.rec_lsu_state     = head.lsu_state;
    assign rec.rec_pc            = head.pc;
    assign rec.rec_instruction   = head.instruction;
endmodule

// File: tb/tb_core_trace_capture.sv
// Bench for core_trace_capture: directed table, corner sequences and
// random traffic checked against a queue-based reference model.
module tb_core_trace_capture;
    localparam int DEPTH = 4;
    localparam int CB    = 4;
    localparam int PB    = 8;
    localparam int DB    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  trigger_mask;
    logic [2:0]  core_state;
    logic [2:0]  fetcher_state;
    logic [1:0]  lsu_state;
    logic [PB-1:0] current_pc;
    logic [15:0] instruction;
    logic [2:0]  count;
    logic        overflow;
    logic [DB-1:0] dropped;

    core_trace_capture_if #(.CYCLE_BITS(CB), .PC_BITS(PB)) rif ();

    core_trace_capture #(
        .DEPTH(DEPTH), .CYCLE_BITS(CB), .PC_BITS(PB), .DROP_BITS(DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .trigger_mask  (trigger_mask),
        .core_state    (core_state),
        .fetcher_state (fetcher_state),
        .lsu_state     (lsu_state),
        .current_pc    (current_pc),
        .instruction   (instruction),
        .rec           (rif),
        .count         (count),
        .overflow      (overflow),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [CB-1:0] cyc;
        logic [2:0]    core;
        logic [2:0]    fetch;
        logic [1:0]    lsu;
        logic [PB-1:0] pc;
        logic [15:0]   ins;
    } mrec_t;

    mrec_t     mq[$];
    int        m_cyc;
    logic [2:0] last_core, last_fetch;
    logic [1:0] last_lsu;
    logic      m_ovf;
    int        m_drop;

    typedef struct {
        logic       en;
        logic [2:0] m;
        logic [2:0] c;
        logic [2:0] f;
        logic       r;
        logic       v;
        int         n;
        logic [3:0] hc;
        logic [2:0] hcore;
        logic [2:0] hf;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic en, logic [2:0] m, logic [2:0] c,
                                logic [2:0] f, logic r, logic v, int n,
                                logic [3:0] hc, logic [2:0] hcore,
                                logic [2:0] hf);
        vec_t t;
        t = '{en, m, c, f, r, v, n, hc, hcore, hf};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit    pop;
        bit    full;
        bit    ev;
        mrec_t r;
        if (reset) begin
            mq.delete();
            m_cyc = 0;
            last_core = 3'd0;
            last_fetch = 3'd0;
            last_lsu = 2'd0;
            m_ovf = 1'b0;
            m_drop = 0;
        end else begin
            pop  = rif.rec_ready && mq.size() > 0;
            full = mq.size() == DEPTH;
            ev = enable && ((trigger_mask[0] && core_state != last_core) ||
                            (trigger_mask[1] && fetcher_state != last_fetch) ||
                            (trigger_mask[2] && lsu_state != last_lsu));
            if (pop) void'(mq.pop_front());
            if (ev) begin
                if (full && !pop) begin
                    m_ovf = 1'b1;
                    if (m_drop < (1 << DB) - 1) m_drop++;
                end else begin
                    r = '{CB'(m_cyc % (1 << CB)), core_state, fetcher_state,
                          lsu_state, current_pc, instruction};
                    mq.push_back(r);
                end
            end
            m_cyc++;
            last_core = core_state;
            last_fetch = fetcher_state;
            last_lsu = lsu_state;
        end
    endtask

    task automatic check_model();
        chk("m_valid", rif.rec_valid, mq.size() != 0);
        chk("m_count", count, mq.size());
        chk("m_overflow", overflow, m_ovf);
        chk("m_dropped", dropped, m_drop);
        if (mq.size() != 0)
            chk("m_head", {rif.rec_cycle, rif.rec_core_state,
                           rif.rec_fetcher_state, rif.rec_lsu_state,
                           rif.rec_pc, rif.rec_instruction}, mq[0]);
    endtask

    task automatic step(input logic rst_i, input logic en_i,
                        input logic [2:0] m_i, input logic [2:0] c_i,
                        input logic [2:0] f_i, input logic [1:0] l_i,
                        input logic rdy_i);
        reset = rst_i;
        enable = en_i;
        trigger_mask = m_i;
        core_state = c_i;
        fetcher_state = f_i;
        lsu_state = l_i;
        rif.rec_ready = rdy_i;
        current_pc = PB'($urandom);
        instruction = 16'($urandom);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] expc[4];
        logic [2:0] c;
        logic [2:0] f;
        logic [1:0] l;

        // cycle, valid/count after the edge, then head cycle/core/fetch
        for (int i = 0; i < 5; i++)
            tbl[i] = mk(1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 3'b001, 1, 0, 0, 1, 1, 5, 1, 0);
        tbl[6]  = mk(1, 3'b001, 1, 0, 0, 1, 1, 5, 1, 0);
        tbl[7]  = mk(1, 3'b001, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 3'b001, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 3'b001, 1, 2, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 3'b001, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 3'b011, 1, 2, 0, 1, 1, 11, 1, 2);
        tbl[12] = mk(1, 3'b011, 1, 1, 0, 1, 2, 11, 1, 2);
        tbl[13] = mk(1, 3'b011, 1, 1, 0, 1, 2, 11, 1, 2);
        tbl[14] = mk(1, 3'b011, 1, 1, 1, 1, 1, 12, 1, 1);
        tbl[15] = mk(1, 3'b011, 1, 1, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        do_reset();
        chk("rst_valid", rif.rec_valid, 1'b0);
        chk("rst_count", count, 3'd0);

        for (int i = 0; i < 16; i++) begin
            step(0, tbl[i].en, tbl[i].m, tbl[i].c, tbl[i].f, 2'd0, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), rif.rec_valid, tbl[i].v);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].n);
            if (tbl[i].v)
                chk($sformatf("tbl%0d_head", i),
                    {rif.rec_cycle, rif.rec_core_state, rif.rec_fetcher_state},
                    {tbl[i].hc, tbl[i].hcore, tbl[i].hf});
        end

        // stamp wraps: events at absolute cycles 17 and 18
        do_reset();
        for (int i = 0; i < 17; i++) step(0, 1, 3'b001, 0, 0, 0, 0);
        step(0, 1, 3'b001, 1, 0, 0, 0);
        step(0, 1, 3'b001, 2, 0, 0, 0);
        chk("wrap_count", count, 3'd2);
        chk("wrap_head1", {rif.rec_cycle, rif.rec_core_state}, {4'd1, 3'd1});
        step(0, 1, 3'b001, 2, 0, 0, 1);
        chk("wrap_head2", {rif.rec_cycle, rif.rec_core_state}, {4'd2, 3'd2});

        // overflow, then push with simultaneous pop at full
        do_reset();
        for (int i = 1; i <= 6; i++) step(0, 1, 3'b001, 3'(i), 0, 0, 0);
        chk("ovf_count", count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_dropped", dropped, 8'd2);
        chk("ovf_head", rif.rec_core_state, 3'd1);
        step(0, 1, 3'b001, 7, 0, 0, 1);
        chk("fullpp_count", count, 3'd4);
        chk("fullpp_dropped", dropped, 8'd2);
        expc = '{3'd2, 3'd3, 3'd4, 3'd7};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), rif.rec_core_state, expc[k]);
            step(0, 1, 3'b001, 7, 0, 0, 1);
        end
        chk("drain_empty", rif.rec_valid, 1'b0);
        step(0, 1, 3'b001, 7, 0, 0, 1);
        chk("pop_empty_count", count, 3'd0);

        // drop counter saturation, then reset mid-drain
        do_reset();
        c = 3'd0;
        for (int i = 0; i < 300; i++) begin
            c = (i % 2 == 0) ? 3'd1 : 3'd2;
            step(0, 1, 3'b001, c, 0, 0, 0);
        end
        chk("sat_dropped", dropped, 8'hFF);
        chk("sat_count", count, 3'd4);
        step(0, 1, 3'b001, c, 0, 0, 1);
        chk("mid_count", count, 3'd3);
        step(1, 1, 3'b001, c, 0, 0, 1);
        chk("mid_rst_valid", rif.rec_valid, 1'b0);
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_drop", dropped, 8'd0);

        // random traffic against the reference model
        do_reset();
        c = 0; f = 0; l = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) c = 3'($urandom);
            if ($urandom_range(0, 2) == 0) f = 3'($urandom);
            if ($urandom_range(0, 3) == 0) l = 2'($urandom);
            step($urandom_range(0, 127) == 0, $urandom_range(0, 9) != 0,
                 3'($urandom), c, f, l, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_trace_capture.md
Name: core_trace_capture

Overview:
- Cycle-accurate trace recorder; sits between core/fetcher/LSU state outputs and the debug formatting helpers.
- Samples core state, fetcher state, LSU state, PC and current instruction; emits one timestamped record each time a selected state field changes.
- Records are buffered in a FIFO and drained over a valid/ready interface by the testbench monitor, which formats and prints them.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- CYCLE_BITS, 16, width of the free-running cycle stamp.
- PC_BITS, 8, program counter width.
- DROP_BITS, 8, width of the dropped-record counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable; no records are generated while low
- trigger_mask  in  3  bit0 = core state, bit1 = fetcher state, bit2 = LSU state change generates a record
- core_state  in  3  core FSM state (IDLE=000 .. DONE=111)
- fetcher_state  in  3  fetcher FSM state (IDLE/FETCHING/FETCHED)
- lsu_state  in  2  LSU FSM state (IDLE/REQUESTING/WAITING/DONE)
- current_pc  in  PC_BITS  PC at the sample cycle
- instruction  in  16  decoded-stage instruction word
- rec_valid  out  1  head record available
- rec_ready  in  1  consumer accepts head record
- rec_cycle  out  CYCLE_BITS  cycle stamp of head record
- rec_core_state  out  3  head record core state
- rec_fetcher_state  out  3  head record fetcher state
- rec_lsu_state  out  2  head record LSU state
- rec_pc  out  PC_BITS  head record PC
- rec_instruction  out  16  head record instruction
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set on the first dropped record
- dropped  out  DROP_BITS  saturating dropped-record count

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; FIFO emptied; cycle counter 0.
  - Previous-state registers loaded with IDLE encodings (000/000/00).
  - Reset asserted mid-drain discards all entries; rec_valid is 0 on the cycle after reset.
- Cycle counter:
  - Increments every non-reset cycle, independent of enable.
  - Wraps 2^CYCLE_BITS-1 -> 0 with no flag.
- Previous-state registers:
  - Update every cycle from the inputs, independent of enable.
- Event detection:
  - event = enable & |(trigger_mask & {lsu_changed, fetcher_changed, core_changed}).
  - A field is "changed" when its input differs from its previous-state register.
  - The record captures the current-cycle inputs and the current counter value.
  - Latency: the record is visible at the FIFO head (rec_valid=1) on the cycle after the event if the FIFO was empty.
- Output interface:
  - Valid/ready: a pop occurs when rec_valid & rec_ready.
  - Head fields are stable while rec_valid=1 and rec_ready=0.
  - rec_valid never deasserts without a pop, except on reset.
- Full and empty:
  - Push when full with no simultaneous pop: the record is dropped, overflow set to 1, dropped incremented, saturating at all-ones. FIFO contents are unchanged.
  - Push when full with a simultaneous pop: both occur; count stays DEPTH; nothing is dropped.
  - Pop when empty: ignored; count stays 0.
  - Push and pop on a non-empty, non-full FIFO: count unchanged.
- overflow and dropped clear only on reset.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. count is tracked explicitly and is the only full/empty source.

Decomposition:
- Shared package trace_pkg:
  - core_state_e, fetcher_state_e and lsu_state_e enum typedefs, matching the encodings used by core, fetcher and LSU.
  - trace_record_t packed struct {cycle, core_state, fetcher_state, lsu_state, pc, instruction}.
  - IDLE reset constants.
- Sub-module trace_fifo: generic synchronous FIFO parameterised on DEPTH and element type, with push/pop/full/empty/count.
- core_trace_capture owns event detection, timestamping and drop accounting.

Test Plan:
- Reset, then enable=1, mask=001; core_state 000->001 at cycle 5 -> one record {cycle=5, core=001}; rec_valid high at cycle 6; count=1.
- mask=001 with fetcher_state toggling and core_state static -> no records; mask=011 with the same stimulus -> one record per fetcher change.
- DEPTH=4, rec_ready=0, 6 core-state changes -> count=4, overflow=1, dropped=2; drained records hold the first 4 states in order.
- FIFO full, then a new event with rec_ready=1 in the same cycle -> count stays 4, dropped unchanged, new record lands at the tail.
- CYCLE_BITS=4, event at cycle 17 -> rec_cycle=1; a following event at cycle 18 -> rec_cycle=2.
- 3 records queued, rec_ready=1 for one cycle, then reset asserted -> next cycle rec_valid=0, count=0, overflow=0, dropped=0.
